// File: rtl/mc_defs_pkg.sv
// -----------------------------------------------------------------------------
// mc_defs
// Shared definitions for the multicycle CPU control path: FSM state encodings,
// primary opcodes, ALUOp codes, ALU control codes and R-type Funct codes.
// The FSM and the control decoder both import this package, so the two always
// agree on the state numbering.
// -----------------------------------------------------------------------------
package mc_defs;

    // FSM state encodings (values 10..15 are never produced by a healthy FSM)
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMP   = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_R_TYPE = 6'b000000;

    // ALUOp: how the ALU control unit interprets the instruction
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;

    // R-type Funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // States in which an instruction finishes (each lasts exactly one cycle)
    function automatic logic is_retire_state(input logic [3:0] st);
        logic r;
        case (st)
            S_MEMWB, S_MEMWR, S_RCOMP, S_BEQ, S_JUMP: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_alu_ctl.sv
// -----------------------------------------------------------------------------
// mc_alu_ctl
// Combinational ALU control: maps ALUOp (from the state decoder) and the R-type
// Funct field to the 4-bit ALU operation select.
// Ports:
//   ALUOp   in  2  00 add, 01 sub, 10 use Funct (11 treated as add)
//   Funct   in  6  IR[5:0]
//   ALUCtl  out 4  ALU operation select
// -----------------------------------------------------------------------------
module mc_alu_ctl
    import mc_defs::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [3:0] ALUCtl
);

    // ALUOp/Funct to ALU operation; anything unrecognised falls back to add
    always_comb begin
        ALUCtl = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUCtl = ALUCTL_ADD;
            ALUOP_SUB: ALUCtl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUCtl = ALUCTL_ADD;
                    FUNCT_SUB: ALUCtl = ALUCTL_SUB;
                    FUNCT_AND: ALUCtl = ALUCTL_AND;
                    FUNCT_OR:  ALUCtl = ALUCTL_OR;
                    FUNCT_SLT: ALUCtl = ALUCTL_SLT;
                    default:   ALUCtl = ALUCTL_ADD;
                endcase
            end
            default: ALUCtl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_decode.sv
// -----------------------------------------------------------------------------
// mc_control_decode
// Sits after the multicycle FSM and turns its State into the datapath control
// word and ALU control, purely combinationally so the FSM timing is untouched.
// Registered side logic: retire pulse, last-branch status, sticky illegal-state
// and hang flags, and optional performance counters.
// Parameters:
//   HANG_LIMIT  cycles with an unchanged State before Hang sets (>= 2)
//   CNT_W       width of the perf counters and of the hang counter
// Configuration macro:
//   PERF_CNT_EN  when defined, builds InstrCnt/CycleCnt; otherwise they read 0
// Ports:
//   Clk, Reset (synchronous, active-high)
//   State[3:0], Opcode[5:0], Funct[5:0], Zero        inputs from FSM/datapath
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUCtl[3:0] combinational controls
//   Retire, BrTaken, IllegalState, Hang               registered status
//   InstrCnt, CycleCnt [CNT_W-1:0]                    perf counters
// -----------------------------------------------------------------------------
module mc_control_decode
    import mc_defs::*;
#(
    parameter int HANG_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       State,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUCtl,
    output logic             Retire,
    output logic             BrTaken,
    output logic             IllegalState,
    output logic             Hang,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam logic [CNT_W-1:0] HANG_FIRE = CNT_W'(HANG_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             pcw_uncond_s;
    logic             pcw_cond_s;
    logic [1:0]       alu_op_s;
    logic [3:0]       alu_ctl_raw_s;
    logic             illegal_s;
    logic             retire_cond_s;
    logic             unused_opcode_s;

    logic             retire_r;
    logic             br_taken_r;
    logic             illegal_r;
    logic             hang_r;
    logic [CNT_W-1:0] hang_cnt_r;
    logic [3:0]       prev_state_r;

    // Opcode has already been consumed by the FSM to choose State; the
    // decoder itself is purely state-driven.
    assign unused_opcode_s = ^Opcode;

    assign illegal_s     = (State > S_JUMP);
    assign retire_cond_s = is_retire_state(State);

    mc_alu_ctl u_alu_ctl (
        .ALUOp  (alu_op_s),
        .Funct  (Funct),
        .ALUCtl (alu_ctl_raw_s)
    );

    // State decode into the datapath control word; all zero during Reset
    always_comb begin
        pcw_uncond_s = 1'b0;
        pcw_cond_s   = 1'b0;
        alu_op_s     = ALUOP_ADD;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        if (Reset) begin
            pcw_uncond_s = 1'b0;
        end else begin
            case (State)
                S_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = 1'b1;
                    pcw_uncond_s = 1'b1;
                    ALUSrcB      = 2'b01;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA  = 1'b1;
                    alu_op_s = ALUOP_FUNCT;
                end
                S_RCOMP: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA    = 1'b1;
                    alu_op_s   = ALUOP_SUB;
                    pcw_cond_s = 1'b1;
                    PCSource   = 2'b01;
                end
                S_JUMP: begin
                    pcw_uncond_s = 1'b1;
                    PCSource     = 2'b10;
                end
                default: pcw_uncond_s = 1'b0;
            endcase
        end
    end

    // PC load and ALU control; an illegal State or Reset drives every control to zero
    always_comb begin
        PCWrite = pcw_uncond_s | (pcw_cond_s & Zero);
        if (Reset || illegal_s) begin
            ALUCtl = 4'b0000;
        end else begin
            ALUCtl = alu_ctl_raw_s;
        end
    end

    // Retire pulse, branch status, sticky fault flags and the hang watchdog
    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_r     <= 1'b0;
            br_taken_r   <= 1'b0;
            illegal_r    <= 1'b0;
            hang_r       <= 1'b0;
            hang_cnt_r   <= {CNT_W{1'b0}};
            prev_state_r <= 4'd0;
        end else begin
            retire_r <= retire_cond_s;
            if (State == S_BEQ) begin
                br_taken_r <= Zero;
            end
            if (illegal_s) begin
                illegal_r <= 1'b1;
            end
            // Count cycles the State has stood still; any change restarts the count
            if (State == prev_state_r) begin
                if (hang_cnt_r != CNT_MAX) begin
                    hang_cnt_r <= hang_cnt_r + CNT_ONE;
                end
            end else begin
                hang_cnt_r <= {CNT_W{1'b0}};
            end
            // Fires one cycle after the count reaches the limit, i.e. HANG_LIMIT
            // cycles after the stuck State was first seen
            if (hang_cnt_r == HANG_FIRE) begin
                hang_r <= 1'b1;
            end
            prev_state_r <= State;
        end
    end

    assign Retire       = retire_r;
    assign BrTaken      = br_taken_r;
    assign IllegalState = illegal_r;
    assign Hang         = hang_r;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt_r;
    logic [CNT_W-1:0] cycle_cnt_r;

    // Free-running perf counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
            cycle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            if (retire_cond_s) begin
                instr_cnt_r <= instr_cnt_r + CNT_ONE;
            end
        end
    end

    assign InstrCnt = instr_cnt_r;
    assign CycleCnt = cycle_cnt_r;
`else
    assign InstrCnt = {CNT_W{1'b0}};
    assign CycleCnt = {CNT_W{1'b0}};
`endif

endmodule
